// File: rtl/cache_refill.sv
// Critical-word-first cache line refill: fetches one line beat by beat from memory after a miss.
// Miss accept to fill valid takes 2*words_per_line+1 cycles minimum; memory and fill handshakes stall the FSM.
module cache_refill #(
  parameter int addr_wid       = 32,
  parameter int word_wid       = 64,
  parameter int words_per_line = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               miss_valid_i,
  output logic                               miss_ready_o,
  input  logic [addr_wid-1:0]                miss_addr_i,
  output logic                               mem_req_o,
  output logic [addr_wid-1:0]                mem_addr_o,
  input  logic                               mem_gnt_i,
  input  logic                               mem_rvalid_i,
  input  logic [word_wid-1:0]                mem_rdata_i,
  input  logic                               mem_err_i,
  output logic                               crit_valid_o,
  output logic [word_wid-1:0]                crit_word_o,
  output logic                               fill_valid_o,
  input  logic                               fill_ready_i,
  output logic [addr_wid-1:0]                fill_addr_o,
  output logic [words_per_line*word_wid-1:0] fill_line_o,
  output logic                               fill_err_o
);

  localparam int BO = $clog2(word_wid / 8);
  localparam int WO = $clog2(words_per_line);
  localparam logic [addr_wid-1:0] line_mask = ~((addr_wid'(1) << (BO + WO)) - addr_wid'(1));

  typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} state_t;

  state_t                                   state_q;
  logic [addr_wid-1:0]                      base_q;
  logic [WO-1:0]                            crit_q;
  logic [WO-1:0]                            k_q;
  logic [words_per_line-1:0][word_wid-1:0]  line_q;
  logic                                     err_q;
  logic                                     rcvd_q;

  logic [WO-1:0] idx;
  logic          last_beat;
  logic          beat_fire;

  assign idx       = crit_q + k_q;
  assign last_beat = (k_q == WO'(words_per_line - 1));

  // Data may arrive together with the grant (captured in REQ) or any later cycle in WAIT.
  assign beat_fire = mem_rvalid_i &&
                     (((state_q == REQ) && mem_gnt_i) || ((state_q == WAIT) && !rcvd_q));

  assign mem_addr_o  = mem_req_o ? (base_q | (addr_wid'(idx) << BO)) : '0;
  assign fill_addr_o = fill_valid_o ? base_q : '0;
  assign fill_line_o = fill_valid_o ? line_q : '0;
  assign fill_err_o  = fill_valid_o & err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      miss_ready_o <= 1'b1;
      mem_req_o    <= 1'b0;
      crit_valid_o <= 1'b0;
      crit_word_o  <= '0;
      fill_valid_o <= 1'b0;
      base_q       <= '0;
      crit_q       <= '0;
      k_q          <= '0;
      line_q       <= '0;
      err_q        <= 1'b0;
      rcvd_q       <= 1'b0;
    end else begin
      crit_valid_o <= 1'b0;
      crit_word_o  <= '0;

      if (beat_fire) begin
        line_q[idx] <= mem_rdata_i;
        err_q       <= err_q | mem_err_i;
        if ((k_q == '0) && !mem_err_i) begin
          crit_valid_o <= 1'b1;
          crit_word_o  <= mem_rdata_i;
        end
      end

      case (state_q)
        IDLE: begin
          if (miss_valid_i) begin
            base_q       <= miss_addr_i & line_mask;
            crit_q       <= miss_addr_i[BO +: WO];
            k_q          <= '0;
            err_q        <= 1'b0;
            rcvd_q       <= 1'b0;
            miss_ready_o <= 1'b0;
            mem_req_o    <= 1'b1;
            state_q      <= REQ;
          end
        end
        REQ: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            rcvd_q    <= mem_rvalid_i;
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          if (rcvd_q || mem_rvalid_i) begin
            rcvd_q <= 1'b0;
            if (last_beat) begin
              fill_valid_o <= 1'b1;
              state_q      <= FILL;
            end else begin
              k_q       <= k_q + 1'b1;
              mem_req_o <= 1'b1;
              state_q   <= REQ;
            end
          end
        end
        FILL: begin
          // Ready is raised only after the handshake, so no miss overlaps the fill.
          if (fill_ready_i) begin
            fill_valid_o <= 1'b0;
            miss_ready_o <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_refill.sv
// Bench for cache_refill: reactive memory model, fill scoreboard, scenario tasks.
module tb_cache_refill;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         miss_valid_i = 1'b0;
  logic         miss_ready_o;
  logic [31:0]  miss_addr_i = '0;
  logic         mem_req_o;
  logic [31:0]  mem_addr_o;
  logic         mem_gnt_i = 1'b0;
  logic         mem_rvalid_i = 1'b0;
  logic [63:0]  mem_rdata_i = '0;
  logic         mem_err_i = 1'b0;
  logic         crit_valid_o;
  logic [63:0]  crit_word_o;
  logic         fill_valid_o;
  logic         fill_ready_i = 1'b0;
  logic [31:0]  fill_addr_o;
  logic [255:0] fill_line_o;
  logic         fill_err_o;

  cache_refill dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .miss_valid_i (miss_valid_i),
    .miss_ready_o (miss_ready_o),
    .miss_addr_i  (miss_addr_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .mem_err_i    (mem_err_i),
    .crit_valid_o (crit_valid_o),
    .crit_word_o  (crit_word_o),
    .fill_valid_o (fill_valid_o),
    .fill_ready_i (fill_ready_i),
    .fill_addr_o  (fill_addr_o),
    .fill_line_o  (fill_line_o),
    .fill_err_o   (fill_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0]  addr;
    logic [255:0] line;
    logic         err;
    int           acc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] req_log[$];
  logic [63:0] crit_log[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Memory model knobs
  int          gnt_stall = 0;
  int          rv_delay  = 0;
  int          err_beat  = -1;
  int          mbeat     = 0;
  logic        pend      = 1'b0;
  int          rv_wait   = 0;
  logic [31:0] pend_addr = '0;

  function automatic logic [63:0] memdat(input logic [31:0] a);
    return {5'b0, a[31:5] ^ 27'h80, 24'h0, 8'hA0 + {6'b0, a[4:3]}};
  endfunction

  function automatic logic [255:0] exp_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 4; i++) l[i*64 +: 64] = memdat(base + 32'(i * 8));
    return l;
  endfunction

  always @(posedge clk_i) cyc++;

  always @(negedge clk_i) if (crit_valid_o) crit_log.push_back(crit_word_o);

  always @(negedge clk_i) begin
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_err_i    = 1'b0;
    mem_rdata_i  = '0;
    if (pend) begin
      if (rv_wait > 0) rv_wait--;
      else begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = memdat(pend_addr);
        mem_err_i    = (mbeat == err_beat);
        mbeat++;
        pend = 1'b0;
      end
    end
    if (mem_req_o && !pend) begin
      if (gnt_stall > 0) gnt_stall--;
      else begin
        mem_gnt_i = 1'b1;
        pend      = 1'b1;
        rv_wait   = rv_delay;
        pend_addr = mem_addr_o;
        req_log.push_back(mem_addr_o);
      end
    end
  end

  task automatic push_exp(input logic [31:0] a, input logic e);
    exp_t x;
    x.addr = a & ~32'h1F;
    x.line = exp_line(x.addr);
    x.err  = e;
    x.acc  = cyc;
    sb.push_back(x);
  endtask

  task automatic do_miss(input logic [31:0] a, input logic e);
    int n = 0;
    @(negedge clk_i);
    while (!miss_ready_o && n < 100) begin @(negedge clk_i); n++; end
    total++;
    if (!miss_ready_o) begin bad++; $display("FAIL miss_accept_timeout ready=%0b need 1", miss_ready_o); end
    miss_valid_i = 1'b1;
    miss_addr_i  = a;
    mbeat        = 0;
    push_exp(a, e);
    @(negedge clk_i);
    miss_valid_i = 1'b0;
  endtask

  // Scoreboard consumer: waits for a fill, compares it every held cycle, then handshakes.
  task automatic drain_fill(input string tag, input int hold, output int lat);
    int   n = 0;
    exp_t x;
    lat = -1;
    while (!fill_valid_o && n < 300) begin @(negedge clk_i); n++; end
    total++;
    if (!fill_valid_o) begin
      bad++; $display("FAIL %s fill_timeout fill_valid=%0b need 1", tag, fill_valid_o);
      return;
    end
    total++;
    if (sb.size() == 0) begin
      bad++; $display("FAIL %s unexpected_fill addr=%h", tag, fill_addr_o);
      return;
    end
    x   = sb.pop_front();
    lat = cyc - x.acc;
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) @(negedge clk_i);
      total++;
      if (fill_valid_o !== 1'b1 || fill_addr_o !== x.addr || fill_line_o !== x.line ||
          fill_err_o !== x.err || miss_ready_o !== 1'b0) begin
        bad++;
        $display("FAIL %s fill_cyc%0d got v=%0b a=%h e=%0b rdy=%0b line=%h need v=1 a=%h e=%0b rdy=0 line=%h",
                 tag, h, fill_valid_o, fill_addr_o, fill_err_o, miss_ready_o, fill_line_o,
                 x.addr, x.err, x.line);
      end
    end
    fill_ready_i = 1'b1;
    @(negedge clk_i);
    fill_ready_i = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk_i);
    total++;
    if (miss_ready_o !== 1'b1 || mem_req_o !== 1'b0 || fill_valid_o !== 1'b0 || crit_valid_o !== 1'b0) begin
      bad++; $display("FAIL reset_held rdy=%0b req=%0b fv=%0b cv=%0b need 1 0 0 0",
                      miss_ready_o, mem_req_o, fill_valid_o, crit_valid_o);
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
    total++;
    if (miss_ready_o !== 1'b1 || mem_req_o !== 1'b0 || mem_addr_o !== '0 || crit_valid_o !== 1'b0 ||
        crit_word_o !== '0 || fill_valid_o !== 1'b0 || fill_addr_o !== '0 ||
        fill_line_o !== '0 || fill_err_o !== 1'b0) begin
      bad++; $display("FAIL reset_idle rdy=%0b req=%0b addr=%h fv=%0b fa=%h need rdy=1 rest 0",
                      miss_ready_o, mem_req_o, mem_addr_o, fill_valid_o, fill_addr_o);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] seq[4];
    int lat;
    seq = '{32'h1018, 32'h1000, 32'h1008, 32'h1010};
    req_log.delete(); crit_log.delete();
    do_miss(32'h1018, 1'b0);
    drain_fill("wrap", 0, lat);
    total++;
    if (req_log.size() != 4) begin
      bad++; $display("FAIL wrap_req_count got %0d need 4", req_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (req_log[i] !== seq[i]) begin
          bad++; $display("FAIL wrap_addr%0d got %h need %h", i, req_log[i], seq[i]);
        end
      end
    end
    total++;
    if (crit_log.size() != 1 || crit_log[0] !== 64'hA3) begin
      bad++; $display("FAIL wrap_crit count=%0d word=%h need 1 00000000000000a3",
                      crit_log.size(), crit_log.size() > 0 ? crit_log[0] : 64'h0);
    end
  endtask

  task automatic test_zero_wait;
    int lat;
    crit_log.delete();
    do_miss(32'h2000, 1'b0);
    drain_fill("zero_wait", 0, lat);
    total++;
    if (lat != 9) begin bad++; $display("FAIL zero_wait_latency got %0d need 9", lat); end
    total++;
    if (crit_log.size() != 1 || crit_log[0] !== memdat(32'h2000)) begin
      bad++; $display("FAIL zero_wait_crit count=%0d need 1 word %h", crit_log.size(), memdat(32'h2000));
    end
  endtask

  task automatic test_backpressure;
    int lat;
    gnt_stall = 5;
    do_miss(32'h5010, 1'b0);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h5010) begin
        bad++; $display("FAIL bp_req_stable%0d req=%0b addr=%h need 1 00005010", i, mem_req_o, mem_addr_o);
      end
      @(negedge clk_i);
    end
    miss_valid_i = 1'b1;
    miss_addr_i  = 32'h5040;
    push_exp(32'h5040, 1'b0);
    drain_fill("bp_fill", 4, lat);
    total++;
    if (miss_ready_o !== 1'b1) begin bad++; $display("FAIL bp_ready_after got %0b need 1", miss_ready_o); end
    @(negedge clk_i);
    miss_valid_i = 1'b0;
    total++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h5040) begin
      bad++; $display("FAIL bp_next_req req=%0b addr=%h need 1 00005040", mem_req_o, mem_addr_o);
    end
    drain_fill("bp_fill2", 0, lat);
  endtask

  task automatic test_bus_error;
    int lat;
    req_log.delete(); crit_log.delete();
    err_beat = 2;
    do_miss(32'h3008, 1'b1);
    drain_fill("err_beat2", 0, lat);
    total++;
    if (req_log.size() != 4) begin bad++; $display("FAIL err_beats got %0d need 4", req_log.size()); end
    total++;
    if (crit_log.size() != 1 || crit_log[0] !== memdat(32'h3008)) begin
      bad++; $display("FAIL err_crit_pulse count=%0d need 1 word %h", crit_log.size(), memdat(32'h3008));
    end
    crit_log.delete();
    err_beat = 0;
    do_miss(32'h3100, 1'b1);
    drain_fill("err_beat0", 0, lat);
    total++;
    if (crit_log.size() != 0) begin bad++; $display("FAIL err0_crit_suppressed count=%0d need 0", crit_log.size()); end
    err_beat = -1;
  endtask

  task automatic test_back_to_back;
    int lat;
    do_miss(32'h4000, 1'b0);
    miss_valid_i = 1'b1;
    miss_addr_i  = 32'h4020;
    push_exp(32'h4020, 1'b0);
    drain_fill("b2b_first", 0, lat);
    total++;
    if (miss_ready_o !== 1'b1) begin bad++; $display("FAIL b2b_ready got %0b need 1", miss_ready_o); end
    @(negedge clk_i);
    miss_valid_i = 1'b0;
    total++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h4020) begin
      bad++; $display("FAIL b2b_second_req req=%0b addr=%h need 1 00004020", mem_req_o, mem_addr_o);
    end
    drain_fill("b2b_second", 0, lat);
  endtask

  task automatic test_reset_mid;
    int   n = 0;
    logic ok = 1'b1;
    req_log.delete();
    rv_delay = 3;
    do_miss(32'h6000, 1'b0);
    while (req_log.size() < 3 && n < 200) begin @(negedge clk_i); n++; end
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    total++;
    if (miss_ready_o !== 1'b1 || mem_req_o !== 1'b0 || req_log.size() != 3) begin
      bad++; $display("FAIL mid_reset_idle rdy=%0b req=%0b beats=%0d need 1 0 3",
                      miss_ready_o, mem_req_o, req_log.size());
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    if (sb.size() > 0) void'(sb.pop_front());
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (fill_valid_o !== 1'b0 || mem_req_o !== 1'b0 || miss_ready_o !== 1'b1) ok = 1'b0;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL mid_reset_quiet got activity after reset need none"); end
    rv_delay = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_wrap();
    test_zero_wait();
    test_backpressure();
    test_bus_error();
    test_back_to_back();
    test_reset_mid();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_leftover got %0d need 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_refill.md
Name: cache_refill

Overview:
- Miss-handling stage directly downstream of the cache tag/data lookup.
- On a miss it takes the missing byte address and fetches the full cache line from backing memory, critical word first, one beat at a time.
- It forwards the critical word early to the cache output mux, then hands the assembled line to the cache data store for write-in.
- It is the sequential replacement for the cache's ad-hoc READ_0..READ_3 fill sequence.

Parameters:
- addr_wid, 32, byte-address width.
- word_wid, 64, memory beat / cache word width in bits; must be a multiple of 8 and a power of two.
- words_per_line, 4, beats per cache line; power of two, at least 2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- miss_valid_i  in  1  miss request valid.
- miss_ready_o  out  1  refill unit can accept a miss.
- miss_addr_i  in  addr_wid  byte address of the missing access.
- mem_req_o  out  1  memory read request.
- mem_addr_o  out  addr_wid  word-aligned byte address of the beat.
- mem_gnt_i  in  1  memory accepted the request.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  word_wid  read data.
- mem_err_i  in  1  bus error, qualified by mem_rvalid_i.
- crit_valid_o  out  1  one-cycle pulse: critical word available.
- crit_word_o  out  word_wid  critical word.
- fill_valid_o  out  1  assembled line valid.
- fill_ready_i  in  1  cache accepts the line.
- fill_addr_o  out  addr_wid  line-aligned base address.
- fill_line_o  out  words_per_line*word_wid  line; word 0 in the LSBs.
- fill_err_o  out  1  line aborted by bus error; valid while fill_valid_o is high.

Behaviour:
- Definitions:
  - BO = log2(word_wid/8), the byte-offset width.
  - WO = log2(words_per_line), the word-offset width.
  - crit = miss_addr_i[BO +: WO].
  - base = miss_addr_i with the low BO+WO bits zeroed.
- States: IDLE, REQ, WAIT, FILL.
- Reset (async, rst_ni low):
  - state = IDLE.
  - All outputs 0, except miss_ready_o = 1.
  - Line buffer, beat counter and error flag cleared.
  - Reset mid-refill abandons the refill; no fill is produced, and any later mem_rvalid_i is ignored while in IDLE.
- IDLE:
  - miss_ready_o = 1.
  - On miss_valid_i: latch base and crit, set beat count k = 0, clear the error flag, go to REQ.
  - miss_ready_o is 0 in every other state.
- REQ:
  - mem_req_o = 1.
  - mem_addr_o = base + (((crit + k) mod words_per_line) << BO); the word index wraps modulo words_per_line.
  - mem_req_o and mem_addr_o hold stable until mem_gnt_i. On mem_gnt_i, go to WAIT.
  - Only one request is outstanding at a time.
- WAIT:
  - mem_req_o = 0.
  - On mem_rvalid_i, write mem_rdata_i into line slot (crit + k) mod words_per_line and OR mem_err_i into the error flag.
  - If k == 0 and mem_err_i == 0: crit_valid_o = 1 and crit_word_o = mem_rdata_i on the next cycle (registered), for exactly one cycle.
  - If k == words_per_line-1: go to FILL. Otherwise k++ and go to REQ.
  - The first request for the next beat is issued the cycle after rvalid.
  - mem_gnt_i and mem_rvalid_i arriving in the same cycle as the request is legal; the FSM still passes through WAIT, so a minimum beat costs 2 cycles.
- Error: after a beat with mem_err_i = 1, the remaining beats are still fetched (the bus is kept consistent) and fill_err_o = 1 at FILL. crit_valid_o is suppressed if the critical beat itself errored.
- FILL:
  - fill_valid_o = 1, with fill_addr_o = base and fill_line_o = buffer.
  - All fill outputs hold stable until fill_ready_i.
  - On fill_ready_i: go to IDLE; miss_ready_o is 1 in the following cycle.
  - A miss is never accepted in the same cycle as the fill handshake.
- Minimum latency, miss accept to fill_valid_o, with gnt and rvalid each in the first possible cycle: 2*words_per_line + 1 cycles.
- Signals not listed for a state are 0 in that state.
- No combinational path from any input to mem_req_o or miss_ready_o.

Test Plan:
- Reset then idle: after rst_ni rises, miss_ready_o = 1 and all other outputs 0. Pulse rst_ni low in WAIT at beat 2 → immediate IDLE and no fill_valid_o; a stray mem_rvalid_i afterwards is ignored.
- Critical-word-first wrap (defaults), miss_addr_i = 0x0000_1018 → mem_addr_o sequence 0x1018, 0x1000, 0x1008, 0x1010. Memory returns 0xA3, 0xA0, 0xA1, 0xA2 → crit_valid_o pulse with crit_word_o = 0xA3; fill_addr_o = 0x1000; fill_line_o words[0..3] = 0xA0, 0xA1, 0xA2, 0xA3.
- Zero-wait memory (gnt and rvalid tied to immediate response), miss at 0x2000 → fill_valid_o asserted 9 cycles after acceptance; crit_word_o = data returned for address 0x2000.
- Backpressure: mem_gnt_i held low 5 cycles → mem_req_o and mem_addr_o stable throughout. fill_ready_i held low 4 cycles → fill_valid_o, fill_line_o and fill_addr_o stable; miss_valid_i held high meanwhile → miss_ready_o stays 0 until the cycle after fill_ready_i.
- Bus error on beat 2 (addr 0x3008, crit = 1) → all 4 beats still requested; fill_err_o = 1 with fill_valid_o; crit_valid_o still pulses. Error on beat 0 → no crit_valid_o pulse.
- Back-to-back misses at 0x4000 then 0x4020 → second miss accepted the cycle after the first fill handshake; fills delivered in order with correct base addresses.
